// File: rtl/fuel_volume_counter_pkg.sv
// Shared types and widths for the fuel volume counter: FSM state codes,
// Q16.8 accumulator geometry and the saturating accumulate helper.
package fuel_pkg;

   localparam int VOL_W  = 16;
   localparam int FRAC_W = 8;
   localparam int ACC_W  = VOL_W + FRAC_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PUMPING = 2'd1,
      ST_DONE    = 2'd2,
      ST_FAULT   = 2'd3
   } fuel_state_e;

   // Clamps at 0xFFFF.FF instead of wrapping.
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                input logic [VOL_W-1:0] inc);
      logic [ACC_W:0] sum;
      sum = {1'b0, acc} + {{(ACC_W + 1 - VOL_W){1'b0}}, inc};
      return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
   endfunction

endpackage

// File: rtl/fuel_volume_counter_if.sv
// Command/status bundle between the fill controller (master) and the counter (slave).
// start/stop/clear are single-cycle pulses sampled on clk; there is no back-pressure.
interface fuel_volume_counter_if;
   import fuel_pkg::*;

   logic             start;
   logic             stop;
   logic             clear;
   logic [VOL_W-1:0] target_ml;
   logic [VOL_W-1:0] volume_ml;
   logic             pump_en;
   logic             done;
   logic             fault;
   logic [1:0]       state;

   modport master (
      output start, stop, clear, target_ml,
      input  volume_ml, pump_en, done, fault, state
   );

   modport slave (
      input  start, stop, clear, target_ml,
      output volume_ml, pump_en, done, fault, state
   );

endinterface

// File: rtl/fuel_volume_counter_pulse_sync_filter.sv
// Two-flop synchroniser plus glitch filter for a slow asynchronous pin; emits a
// registered one-clock tick on each accepted rising level.
module pulse_sync_filter #(
   parameter int FILTER_CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin_i,
   output logic rise_o
);

   localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // cnt_q counts consecutive synced samples that disagree with the accepted level.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/fuel_volume_counter.sv
// Flow-pulse to millilitre counter with the pump fill-cycle FSM
// (IDLE -> PUMPING -> DONE, or FAULT on loss of flow).
module fuel_volume_counter
   import fuel_pkg::*;
#(
   parameter int unsigned ML_PER_PULSE_Q8 = 569,
   parameter int          FILTER_CYCLES   = 8,
   parameter int unsigned NO_FLOW_CYCLES  = 50_000_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flow_pin,
   fuel_volume_counter_if.slave  bus
);

   localparam int               TO_W = $clog2(NO_FLOW_CYCLES + 1);
   localparam logic [VOL_W-1:0] INC  = VOL_W'(ML_PER_PULSE_Q8);

   fuel_state_e       state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [VOL_W-1:0]  target_q, target_d;
   logic [TO_W-1:0]   idle_q, idle_d;
   logic              pump_en_q, done_q, fault_q;
   logic              tick;
   logic              arm;

   pulse_sync_filter #(
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_flow_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (flow_pin),
      .rise_o (tick)
   );

   // Done is judged on the post-tick accumulator so pump_en falls on the same
   // edge that volume_ml first reaches the target.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      target_d = target_q;
      idle_d   = idle_q;
      arm      = bus.start && (bus.target_ml != '0);

      if (bus.clear) begin
         state_d = ST_IDLE;
         acc_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arm) begin
                  state_d  = ST_PUMPING;
                  target_d = bus.target_ml;
                  acc_d    = '0;
                  idle_d   = '0;
               end
            end
            ST_PUMPING: begin
               if (tick) acc_d = sat_add(acc_q, INC);
               if (bus.stop) begin
                  state_d = ST_IDLE;
               end else if (acc_d[ACC_W-1 -: VOL_W] >= target_q) begin
                  state_d = ST_DONE;
               end else if (tick) begin
                  idle_d = '0;
               end else begin
                  idle_d = idle_q + TO_W'(1);
                  if (idle_d == TO_W'(NO_FLOW_CYCLES)) state_d = ST_FAULT;
               end
            end
            ST_DONE: begin
               // Drip after the target still counts until the next start.
               if (arm) begin
                  state_d  = ST_PUMPING;
                  target_d = bus.target_ml;
                  acc_d    = '0;
                  idle_d   = '0;
               end else if (tick) begin
                  acc_d = sat_add(acc_q, INC);
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         target_q  <= '0;
         idle_q    <= '0;
         pump_en_q <= 1'b0;
         done_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         target_q  <= target_d;
         idle_q    <= idle_d;
         pump_en_q <= (state_d == ST_PUMPING);
         done_q    <= (state_d == ST_DONE);
         fault_q   <= (state_d == ST_FAULT);
      end
   end

   assign bus.volume_ml = acc_q[ACC_W-1 -: VOL_W];
   assign bus.pump_en   = pump_en_q;
   assign bus.done      = done_q;
   assign bus.fault     = fault_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_fuel_volume_counter.sv
// Bench for fuel_volume_counter: two instances (569 and 0xFFFF ml/pulse Q8) share
// one stimulus stream; a window-filter/integer-volume model predicts every cycle.
module tb_fuel_volume_counter;

   localparam int          F     = 8;
   localparam int unsigned NF    = 100;
   localparam int unsigned ACC_M = 32'h00FF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flow_pin = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] target = 16'd0;

   int n_tests = 0;
   int n_fail  = 0;

   fuel_volume_counter_if bus_a ();
   fuel_volume_counter_if bus_b ();

   assign bus_a.start = start;
   assign bus_a.stop = stop;
   assign bus_a.clear = clear;
   assign bus_a.target_ml = target;
   assign bus_b.start = start;
   assign bus_b.stop = stop;
   assign bus_b.clear = clear;
   assign bus_b.target_ml = target;

   fuel_volume_counter #(
      .ML_PER_PULSE_Q8 (569),
      .FILTER_CYCLES   (F),
      .NO_FLOW_CYCLES  (NF)
   ) dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .flow_pin (flow_pin),
      .bus      (bus_a.slave)
   );

   fuel_volume_counter #(
      .ML_PER_PULSE_Q8 (65535),
      .FILTER_CYCLES   (F),
      .NO_FLOW_CYCLES  (NF)
   ) dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .flow_pin (flow_pin),
      .bus      (bus_b.slave)
   );

   // clock / reset
   always #5 clk = ~clk;

   logic [20:0] act_a, act_b;
   assign act_a = {bus_a.state, bus_a.pump_en, bus_a.done, bus_a.fault, bus_a.volume_ml};
   assign act_b = {bus_b.state, bus_b.pump_en, bus_b.done, bus_b.fault, bus_b.volume_ml};

   // model: state 0 idle,1 pumping,2 done,3 fault; acc in 1/256 ml
   int unsigned m_inc [2] = '{569, 65535};
   int          m_st  [2] = '{0, 0};
   int unsigned m_acc [2] = '{0, 0};
   int unsigned m_tgt [2] = '{0, 0};
   int unsigned m_idle[2] = '{0, 0};
   logic [F+1:0] m_hist = '0;
   bit           m_filt = 1'b0;
   bit           m_tick = 1'b0;
   logic [20:0]  exp_a_q[$];
   logic [20:0]  exp_b_q[$];

   function automatic int unsigned m_sat(input int unsigned x);
      return (x > ACC_M) ? ACC_M : x;
   endfunction

   function automatic logic [20:0] expect_of(input int d);
      logic [1:0]  s;
      logic [15:0] v;
      s = m_st[d][1:0];
      v = m_acc[d][23:8];
      return {s, (m_st[d] == 1), (m_st[d] == 2), (m_st[d] == 3), v};
   endfunction

   task automatic m_arm(input int d);
      m_st[d]   = 1;
      m_tgt[d]  = {16'd0, target};
      m_acc[d]  = 0;
      m_idle[d] = 0;
   endtask

   task automatic m_step(input int d, input bit tk);
      bit arm_ok;
      arm_ok = start && (target != 16'd0);
      if (clear) begin
         m_st[d]  = 0;
         m_acc[d] = 0;
      end else if (m_st[d] == 0) begin
         if (arm_ok) m_arm(d);
      end else if (m_st[d] == 1) begin
         if (tk) m_acc[d] = m_sat(m_acc[d] + m_inc[d]);
         if (stop) m_st[d] = 0;
         else if ((m_acc[d] >> 8) >= m_tgt[d]) m_st[d] = 2;
         else if (tk) m_idle[d] = 0;
         else begin
            m_idle[d]++;
            if (m_idle[d] >= NF) m_st[d] = 3;
         end
      end else if (m_st[d] == 2) begin
         if (arm_ok) m_arm(d);
         else if (tk) m_acc[d] = m_sat(m_acc[d] + m_inc[d]);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            m_st[d] = 0; m_acc[d] = 0; m_tgt[d] = 0; m_idle[d] = 0;
         end
         m_hist = '0;
         m_filt = 1'b0;
         m_tick = 1'b0;
         exp_a_q.delete();
         exp_b_q.delete();
      end else begin
         for (int d = 0; d < 2; d++) m_step(d, m_tick);
         // pin seen by the filter lags the pin by two synchroniser stages
         m_hist = {m_hist[F:0], flow_pin};
         m_tick = 1'b0;
         if (!m_filt && (&m_hist[F+1:2])) begin
            m_filt = 1'b1;
            m_tick = 1'b1;
         end else if (m_filt && !(|m_hist[F+1:2])) begin
            m_filt = 1'b0;
         end
      end
      exp_a_q.push_back(expect_of(0));
      exp_b_q.push_back(expect_of(1));
   end

   // scoreboard
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (exp_a_q.size() > 0) check("cycle_a", 32'(act_a), 32'(exp_a_q.pop_front()));
      if (exp_b_q.size() > 0) check("cycle_b", 32'(act_b), 32'(exp_b_q.pop_front()));
   end

   // drivers (called and returning on a negedge)
   task automatic cmd(input bit s, input bit p, input bit c, input logic [15:0] t);
      start = s; stop = p; clear = c; target = t;
      @(negedge clk);
      start = 1'b0; stop = 1'b0; clear = 1'b0;
   endtask

   task automatic pulse(input int hi, input int lo);
      flow_pin = 1'b1;
      repeat (hi) @(negedge clk);
      flow_pin = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_a", 32'(act_a), 32'd0);
      check("reset_b", 32'(act_b), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: target 100, 45 pulses; DONE on the edge volume reaches 100
      cmd(1'b1, 1'b0, 1'b0, 16'd100);
      check("t1_pump_on", 32'(bus_a.pump_en), 32'd1);
      repeat (44) pulse(10, 10);
      flow_pin = 1'b1;
      repeat (10) @(negedge clk);
      flow_pin = 1'b0;
      check("t1_vol44", 32'(bus_a.volume_ml), 32'd97);
      check("t1_pump44", 32'(bus_a.pump_en), 32'd1);
      @(negedge clk);
      check("t1_vol45", 32'(bus_a.volume_ml), 32'd100);
      check("t1_pump45", 32'(bus_a.pump_en), 32'd0);
      check("t1_done", 32'(bus_a.done), 32'd1);
      repeat (9) @(negedge clk);

      // 2: re-arm from DONE, target 20; drip in DONE keeps counting
      cmd(1'b1, 1'b0, 1'b0, 16'd20);
      repeat (9) pulse(10, 10);
      check("t2_vol9", 32'(bus_a.volume_ml), 32'd20);
      check("t2_state9", 32'(bus_a.state), 32'd2);
      repeat (3) pulse(10, 10);
      check("t2_vol12", 32'(bus_a.volume_ml), 32'd26);
      check("t2_pump", 32'(bus_a.pump_en), 32'd0);

      // 3: glitches F-1 wide ignored, F-wide pulse counted after F+3 clocks
      cmd(1'b1, 1'b0, 1'b0, 16'd1000);
      repeat (3) pulse(F - 1, 10);
      check("t3_glitch", 32'(bus_a.volume_ml), 32'd0);
      flow_pin = 1'b1;
      repeat (F) @(negedge clk);
      flow_pin = 1'b0;
      repeat (2) @(negedge clk);
      check("t3_lat_early", 32'(bus_a.volume_ml), 32'd0);
      @(negedge clk);
      check("t3_lat_exact", 32'(bus_a.volume_ml), 32'd2);
      repeat (10) @(negedge clk);

      // 4: no flow for NF clocks -> FAULT; start ignored; clear -> IDLE
      cmd(1'b0, 1'b0, 1'b1, 16'd0);
      cmd(1'b1, 1'b0, 1'b0, 16'd1000);
      repeat (99) @(negedge clk);
      check("t4_not_yet", 32'(bus_a.fault), 32'd0);
      @(negedge clk);
      check("t4_fault", 32'({bus_a.state, bus_a.fault, bus_a.pump_en}), 32'b1110);
      cmd(1'b1, 1'b0, 1'b0, 16'd50);
      check("t4_start_ign", 32'(bus_a.state), 32'd3);
      cmd(1'b0, 1'b0, 1'b1, 16'd0);
      check("t4_clear", 32'(act_a), 32'd0);

      // 5: clear beats start; stop with a tick keeps the tick; zero target ignored
      cmd(1'b1, 1'b0, 1'b1, 16'd1000);
      check("t5_clr_start", 32'(bus_a.state), 32'd0);
      cmd(1'b1, 1'b0, 1'b0, 16'd1000);
      flow_pin = 1'b1;
      repeat (F) @(negedge clk);
      flow_pin = 1'b0;
      repeat (2) @(negedge clk);
      cmd(1'b0, 1'b1, 1'b0, 16'd0);
      check("t5_stop_tick", 32'({bus_a.state, bus_a.volume_ml}), 32'd2);
      repeat (10) @(negedge clk);
      cmd(1'b1, 1'b0, 1'b0, 16'd0);
      check("t5_zero_tgt", 32'({bus_a.state, bus_a.volume_ml}), 32'd2);

      // 6: async reset mid-fill, then saturation on the 0xFFFF instance
      cmd(1'b1, 1'b0, 1'b0, 16'd1000);
      repeat (3) pulse(10, 10);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_a", 32'(act_a), 32'd0);
      check("t6_rst_b", 32'(act_b), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cmd(1'b1, 1'b0, 1'b0, 16'hFFFF);
      repeat (255) pulse(10, 10);
      check("t6_b255", 32'({bus_b.state, bus_b.volume_ml}), 32'h1_FF00 - 32'd256 + 32'h0_00FF);
      pulse(10, 10);
      check("t6_b256", 32'({bus_b.state, bus_b.volume_ml}), 32'h2_FFFF);
      repeat (2) pulse(10, 10);
      check("t6_b_sat", 32'({bus_b.state, bus_b.done, bus_b.volume_ml}), 32'h5_FFFF);
      check("t6_a258", 32'({bus_a.state, bus_a.volume_ml}), 32'h1_0000 + 32'd573);

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: stimulus did not complete by %0t", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
